// File: rtl/ide_pio_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ide_pio_sequencer: turns a CPU IDE-window access into a timed ATA PIO    |
// | cycle (setup, IORDY-extended strobe, hold, recover). Revision 1.0        |
// +--------------------------------------------------------------------------+
module ide_pio_sequencer #(
  parameter int T_SETUP       = 2,
  parameter int T_ACTIVE      = 6,
  parameter int T_HOLD        = 2,
  parameter int T_RECOVER     = 3,
  parameter int IORDY_TIMEOUT = 200
) (
  input  logic        CLKCPU,
  input  logic        RESET,
  input  logic        CS,
  input  logic        DS,
  input  logic        RW,
  input  logic        A12,
  input  logic [2:0]  A,
  input  logic [15:0] DIN,
  output logic [15:0] DOUT,
  output logic        DSACK,
  output logic        TIMEOUT,
  output logic        IDE_CS0_N,
  output logic        IDE_CS1_N,
  output logic [2:0]  IDE_DA,
  output logic        IDE_DIOR_N,
  output logic        IDE_DIOW_N,
  input  logic        IDE_IORDY,
  input  logic [15:0] IDE_DIN,
  output logic [15:0] IDE_DOUT,
  output logic        IDE_DOE
);

  localparam logic [7:0] C_SETUP   = 8'(T_SETUP - 1);
  localparam logic [7:0] C_ACTIVE  = 8'(T_ACTIVE - 1);
  localparam logic [7:0] C_HOLD    = 8'(T_HOLD - 1);
  localparam logic [7:0] C_RECOVER = 8'(T_RECOVER - 1);
  localparam logic [7:0] C_TIMEOUT = 8'(IORDY_TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACTIVE  = 3'd2,
    S_HOLD    = 3'd3,
    S_ACK     = 3'd4,
    S_RECOVER = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  count_q, count_d;
  logic [7:0]  wait_q, wait_d;
  logic        ds_q;
  logic        rw_q, rw_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] ide_dout_q, ide_dout_d;
  logic [2:0]  da_q, da_d;
  logic        dsack_q, dsack_d;
  logic        timeout_q, timeout_d;
  logic        cs0_n_q, cs0_n_d;
  logic        cs1_n_q, cs1_n_d;
  logic        dior_n_q, dior_n_d;
  logic        diow_n_q, diow_n_d;
  logic        doe_q, doe_d;

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    wait_d     = wait_q;
    rw_d       = rw_q;
    dout_d     = dout_q;
    ide_dout_d = ide_dout_q;
    da_d       = da_q;
    dsack_d    = dsack_q;
    timeout_d  = 1'b0;
    cs0_n_d    = cs0_n_q;
    cs1_n_d    = cs1_n_q;
    dior_n_d   = dior_n_q;
    diow_n_d   = diow_n_q;
    doe_d      = doe_q;

    case (state_q)
      S_IDLE: begin
        // ds_q gates on a fresh DS falling edge so a held strobe cannot retrigger
        if (!CS && !DS && ds_q) begin
          rw_d    = RW;
          da_d    = A;
          cs0_n_d = A12;
          cs1_n_d = !A12;
          if (!RW) begin
            doe_d      = 1'b1;
            ide_dout_d = DIN;
          end
          count_d = C_SETUP;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (DS) begin
          cs0_n_d = 1'b1;
          cs1_n_d = 1'b1;
          doe_d   = 1'b0;
          count_d = C_RECOVER;
          state_d = S_RECOVER;
        end else if (count_q == 8'd0) begin
          if (rw_q) dior_n_d = 1'b0;
          else      diow_n_d = 1'b0;
          count_d = C_ACTIVE;
          wait_d  = 8'd0;
          state_d = S_ACTIVE;
        end else begin
          count_d = count_q - 8'd1;
        end
      end
      S_ACTIVE: begin
        if (count_q != 8'd0) begin
          count_d = count_q - 8'd1;
        end else if (IDE_IORDY || (wait_q == C_TIMEOUT)) begin
          timeout_d = !IDE_IORDY;
          dior_n_d  = 1'b1;
          diow_n_d  = 1'b1;
          if (rw_q) dout_d = IDE_DIN;
          count_d = C_HOLD;
          state_d = S_HOLD;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_HOLD: begin
        if (count_q != 8'd0) begin
          count_d = count_q - 8'd1;
        end else begin
          cs0_n_d = 1'b1;
          cs1_n_d = 1'b1;
          doe_d   = 1'b0;
          if (!DS) begin
            dsack_d = 1'b0;
            state_d = S_ACK;
          end else begin
            count_d = C_RECOVER;
            state_d = S_RECOVER;
          end
        end
      end
      S_ACK: begin
        if (DS) begin
          dsack_d = 1'b1;
          count_d = C_RECOVER;
          state_d = S_RECOVER;
        end
      end
      S_RECOVER: begin
        if (count_q != 8'd0) count_d = count_q - 8'd1;
        else                 state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKCPU) begin
    ds_q <= DS;
    if (RESET) begin
      state_q    <= S_IDLE;
      count_q    <= 8'd0;
      wait_q     <= 8'd0;
      rw_q       <= 1'b0;
      dout_q     <= 16'd0;
      ide_dout_q <= 16'd0;
      da_q       <= 3'd0;
      dsack_q    <= 1'b1;
      timeout_q  <= 1'b0;
      cs0_n_q    <= 1'b1;
      cs1_n_q    <= 1'b1;
      dior_n_q   <= 1'b1;
      diow_n_q   <= 1'b1;
      doe_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      wait_q     <= wait_d;
      rw_q       <= rw_d;
      dout_q     <= dout_d;
      ide_dout_q <= ide_dout_d;
      da_q       <= da_d;
      dsack_q    <= dsack_d;
      timeout_q  <= timeout_d;
      cs0_n_q    <= cs0_n_d;
      cs1_n_q    <= cs1_n_d;
      dior_n_q   <= dior_n_d;
      diow_n_q   <= diow_n_d;
      doe_q      <= doe_d;
    end
  end

  assign DOUT       = dout_q;
  assign DSACK      = dsack_q;
  assign TIMEOUT    = timeout_q;
  assign IDE_CS0_N  = cs0_n_q;
  assign IDE_CS1_N  = cs1_n_q;
  assign IDE_DA     = da_q;
  assign IDE_DIOR_N = dior_n_q;
  assign IDE_DIOW_N = diow_n_q;
  assign IDE_DOUT   = ide_dout_q;
  assign IDE_DOE    = doe_q;

endmodule
`default_nettype wire

// File: tb/tb_ide_pio_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_ide_pio_sequencer: table-driven PIO transactions plus abort, reset    |
// | and retrigger sequences. Revision 1.0                                    |
// +--------------------------------------------------------------------------+
module tb_ide_pio_sequencer;

  logic        clk = 1'b0;
  logic        RESET = 1'b1;
  logic        CS = 1'b1, DS = 1'b1, RW = 1'b1, A12 = 1'b0;
  logic [2:0]  A = 3'd0;
  logic [15:0] DIN = 16'd0, IDE_DIN = 16'd0;
  logic        IDE_IORDY = 1'b1;
  logic [15:0] DOUT, IDE_DOUT;
  logic        DSACK, TIMEOUT, IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, IDE_DOE;
  logic [2:0]  IDE_DA;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ide_pio_sequencer dut (
    .CLKCPU(clk), .RESET(RESET), .CS(CS), .DS(DS), .RW(RW), .A12(A12), .A(A),
    .DIN(DIN), .DOUT(DOUT), .DSACK(DSACK), .TIMEOUT(TIMEOUT),
    .IDE_CS0_N(IDE_CS0_N), .IDE_CS1_N(IDE_CS1_N), .IDE_DA(IDE_DA),
    .IDE_DIOR_N(IDE_DIOR_N), .IDE_DIOW_N(IDE_DIOW_N), .IDE_IORDY(IDE_IORDY),
    .IDE_DIN(IDE_DIN), .IDE_DOUT(IDE_DOUT), .IDE_DOE(IDE_DOE)
  );

  typedef struct {
    logic        rw;
    logic        a12;
    logic [2:0]  a;
    logic [15:0] din;
    logic [15:0] ide_din;
    int          extra;     // IORDY-low cycles past the strobe count (255 = never ready)
    int          exp_len;
    logic [15:0] exp_dout;
    int          exp_to;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] idle_vec();
    return {22'd0, DSACK, IDE_CS0_N, IDE_CS1_N, IDE_DIOR_N, IDE_DIOW_N, IDE_DOE,
            IDE_DA, IDE_DOUT, DOUT, TIMEOUT};
  endfunction

  localparam logic [63:0] RESET_VEC = {22'd0, 5'b11111, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0};

  task automatic run_txn(input vec_t v, input string tag);
    int first_stb = -1, stb_len = 0, cs_rise = -1, ack_k = -1, rel_k = -1, to_cnt = 0;
    bit bad_other = 0, bad_cs = 0, bad_da = 0, bad_doe = 0, bad_ackhold = 0, dsack_back = 0;
    logic stb, oth, sel, uns;
    RW = v.rw; A12 = v.a12; A = v.a; DIN = v.din; IDE_DIN = v.ide_din;
    IDE_IORDY = (v.extra == 0);
    CS = 1'b0; DS = 1'b0;
    for (int k = 0; k < 400; k++) begin
      tick();
      stb = v.rw ? IDE_DIOR_N : IDE_DIOW_N;
      oth = v.rw ? IDE_DIOW_N : IDE_DIOR_N;
      sel = v.a12 ? IDE_CS1_N : IDE_CS0_N;
      uns = v.a12 ? IDE_CS0_N : IDE_CS1_N;
      if (!stb) begin
        if (first_stb < 0) first_stb = k;
        stb_len++;
      end
      if (!oth) bad_other = 1;
      if (!uns) bad_cs = 1;
      if (!sel) begin
        if (cs_rise >= 0) bad_cs = 1;
        if (IDE_DA !== v.a) bad_da = 1;
        if (IDE_DOE !== !v.rw) bad_doe = 1;
        if (!v.rw && IDE_DOUT !== v.din) bad_doe = 1;
      end else begin
        if (cs_rise < 0) cs_rise = k;
        if (IDE_DOE !== 1'b0) bad_doe = 1;
      end
      if (TIMEOUT) to_cnt++;
      IDE_IORDY = (stb_len >= 6 + v.extra);
      if (!DSACK && ack_k < 0) ack_k = k;
      if (ack_k >= 0 && rel_k < 0 && DSACK) bad_ackhold = 1;
      if (ack_k >= 0 && rel_k < 0 && k == ack_k + 2) begin
        DS = 1'b1; CS = 1'b1; rel_k = k;
      end
      if (rel_k >= 0 && k == rel_k + 1) dsack_back = DSACK;
      if (rel_k >= 0 && k == rel_k + 6) break;
    end
    IDE_IORDY = 1'b1;
    check({tag, " first_strobe"}, 64'(first_stb), 64'd2);
    check({tag, " strobe_len"}, 64'(stb_len), 64'(v.exp_len));
    check({tag, " cs_rise"}, 64'(cs_rise), 64'(v.exp_len + 4));
    check({tag, " dsack_low_at"}, 64'(ack_k), 64'(v.exp_len + 4));
    check({tag, " other_strobe_low"}, 64'(bad_other), 64'd0);
    check({tag, " wrong_cs"}, 64'(bad_cs), 64'd0);
    check({tag, " da"}, 64'(bad_da), 64'd0);
    check({tag, " doe_data"}, 64'(bad_doe), 64'd0);
    check({tag, " dsack_hold"}, 64'(bad_ackhold), 64'd0);
    check({tag, " dsack_release"}, 64'(dsack_back), 64'd1);
    check({tag, " timeout_pulses"}, 64'(to_cnt), 64'(v.exp_to));
    check({tag, " dout"}, 64'(DOUT), 64'(v.exp_dout));
  endtask

  initial begin
    int n;
    bit flag;

    //          rw    a12   a     din       ide_din   extra len  exp_dout  to
    vecs[0] = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h50A0, 0,    6,   16'h50A0, 0};
    vecs[1] = '{1'b0, 1'b1, 3'd6, 16'h0004, 16'h1234, 0,    6,   16'h50A0, 0};
    vecs[2] = '{1'b1, 1'b0, 3'd3, 16'h0000, 16'h0F0F, 10,   16,  16'h0F0F, 0};
    vecs[3] = '{1'b0, 1'b0, 3'd2, 16'hBEEF, 16'h5555, 10,   16,  16'h0F0F, 0};
    vecs[4] = '{1'b1, 1'b1, 3'd1, 16'h0000, 16'hC3C3, 255,  206, 16'hC3C3, 1};

    repeat (3) tick();
    check("reset_state", idle_vec(), RESET_VEC);
    RESET = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

    // CPU abort during SETUP: write, DS released right after the start edge
    RW = 1'b0; A12 = 1'b0; A = 3'd5; DIN = 16'hAAAA; CS = 1'b0; DS = 1'b0;
    tick();
    check("abort_setup cs0_low", {IDE_CS0_N, IDE_DOE}, 2'b01);
    DS = 1'b1; CS = 1'b1;
    tick();
    check("abort_setup cs0_released", {IDE_CS0_N, IDE_DOE}, 2'b10);
    flag = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (!IDE_DIOW_N || !IDE_DIOR_N || !DSACK || !IDE_CS0_N) flag = 1;
    end
    check("abort_setup no_strobe_no_ack", 64'(flag), 64'd0);

    // CPU abort during ACTIVE: strobe still runs its full width, no DSACK
    RW = 1'b1; A12 = 1'b0; A = 3'd0; IDE_DIN = 16'h1111; CS = 1'b0; DS = 1'b0;
    n = 0; flag = 0;
    begin
      int cs_rise = -1;
      for (int k = 0; k < 25; k++) begin
        tick();
        if (!IDE_DIOR_N) begin
          n++;
          if (n == 1) begin DS = 1'b1; CS = 1'b1; end
        end
        if (!DSACK) flag = 1;
        if (IDE_CS0_N && cs_rise < 0) cs_rise = k;
      end
      check("abort_active strobe_len", 64'(n), 64'd6);
      check("abort_active cs_rise", 64'(cs_rise), 64'd10);
    end
    check("abort_active no_dsack", 64'(flag), 64'd0);
    check("abort_active dout", 64'(DOUT), 64'h1111);

    // Reset in the middle of the strobe
    RW = 1'b1; A12 = 1'b1; A = 3'd4; CS = 1'b0; DS = 1'b0;
    n = 0;
    for (int i = 0; i < 20 && n < 3; i++) begin
      tick();
      if (!IDE_DIOR_N) n++;
    end
    check("reset_mid strobe_seen", 64'(n), 64'd3);
    RESET = 1'b1;
    tick();
    check("reset_mid outputs", idle_vec(), RESET_VEC);
    RESET = 1'b0; CS = 1'b1; DS = 1'b1;
    repeat (2) tick();
    run_txn(vecs[0], "post_reset");

    // DS held in ACK, re-request during RECOVER must not retrigger
    RW = 1'b1; A12 = 1'b0; A = 3'd7; IDE_DIN = 16'h7E7E; CS = 1'b0; DS = 1'b0;
    n = 0;
    for (int i = 0; i < 40 && DSACK; i++) begin
      tick();
      n++;
    end
    check("retrig dsack_low", 64'(DSACK), 64'd0);
    repeat (3) tick();
    check("retrig dsack_held", 64'(DSACK), 64'd0);
    DS = 1'b1;
    tick();
    check("retrig dsack_release", 64'(DSACK), 64'd1);
    DS = 1'b0;
    flag = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (!IDE_CS0_N || !IDE_CS1_N || !IDE_DIOR_N || !IDE_DIOW_N || !DSACK) flag = 1;
    end
    check("retrig no_second_cycle", 64'(flag), 64'd0);
    DS = 1'b1;
    tick();
    DS = 1'b0;
    tick();
    check("retrig fresh_start", {IDE_CS0_N, IDE_CS1_N}, 2'b01);
    for (int i = 0; i < 40 && DSACK; i++) tick();
    check("retrig fresh_ack", 64'(DSACK), 64'd0);
    check("retrig fresh_dout", 64'(DOUT), 64'h7E7E);
    DS = 1'b1; CS = 1'b1;
    repeat (6) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ide_pio_sequencer.md
Name: ide_pio_sequencer

Overview:
- Sequences CPU PIO accesses to the IDE drive behind the Gayle IDE window.
- Converts a CPU bus cycle (CS/DS/RW) into a timed ATA PIO cycle: address/chip-select setup, DIOR/DIOW strobe with IORDY extension, hold, and recovery.
- Returns DSACK to the CPU once the cycle completes and captures read data.
- Sits between the CPU bus decode and the IDE connector, beside the Gayle register block, which keeps handling IDE_INT and INT2.

Parameters:
- T_SETUP, 2, cycles CS/DA are stable before the strobe asserts (1..255)
- T_ACTIVE, 6, minimum strobe-low cycles (1..255)
- T_HOLD, 2, cycles CS/DA/write data are held after the strobe negates (1..255)
- T_RECOVER, 3, cycles CS is negated before the next cycle may start (1..255)
- IORDY_TIMEOUT, 200, maximum extra ACTIVE cycles while IORDY is low (1..255)

Ports:
- CLKCPU  in  1  CPU clock; the only clock
- RESET  in  1  synchronous reset, active-high
- CS  in  1  IDE window select, active-low (decoded upstream)
- DS  in  1  CPU data strobe, active-low
- RW  in  1  1 = read, 0 = write
- A12  in  1  0 = command block (CS0), 1 = control block (CS1)
- A  in  3  IDE register address (DA2..DA0)
- DIN  in  16  CPU write data
- DOUT  out  16  latched read data
- DSACK  out  1  cycle acknowledge to the CPU, active-low
- TIMEOUT  out  1  one-cycle pulse when the IORDY wait expires
- IDE_CS0_N  out  1  drive chip-select 0, active-low
- IDE_CS1_N  out  1  drive chip-select 1, active-low
- IDE_DA  out  3  drive register address
- IDE_DIOR_N  out  1  read strobe, active-low
- IDE_DIOW_N  out  1  write strobe, active-low
- IDE_IORDY  in  1  drive ready (pre-synchronised), high = ready
- IDE_DIN  in  16  data from the drive
- IDE_DOUT  out  16  data to the drive
- IDE_DOE  out  1  drive IDE_DOUT onto the bus

Behaviour:
- All outputs are registered.
- Reset values (RESET=1 on any edge, including mid-cycle): state=IDLE, DSACK=1, IDE_CS0_N=1, IDE_CS1_N=1, IDE_DIOR_N=1, IDE_DIOW_N=1, IDE_DOE=0, IDE_DA=0, IDE_DOUT=0, DOUT=0, TIMEOUT=0, counters=0.
- An in-flight strobe is cut at the reset edge; no DSACK is issued.
- States: IDLE, SETUP, ACTIVE, HOLD, ACK, RECOVER.
- IDLE:
  - Start when CS=0 and DS=0 are sampled, and ds_d=1 (DS was high on the previous edge).
  - The start requirement means a held DS cannot retrigger a cycle.
  - At the start edge, latch A12, A, RW and DIN.
  - Drive IDE_DA=A and the selected CSx_N=0.
  - For a write, set IDE_DOE=1 and IDE_DOUT=DIN.
  - Go to SETUP with count=T_SETUP-1.
- SETUP:
  - Counts down; at 0, assert DIOR_N (read) or DIOW_N (write) and enter ACTIVE with count=T_ACTIVE-1.
  - First strobe-low cycle = start edge + T_SETUP + 1.
  - If DS is sampled high in SETUP (CPU abort): negate CSx_N and IDE_DOE, go to RECOVER, no strobe, no DSACK.
- ACTIVE:
  - Counts down; at count=0, leave only if IORDY=1.
  - While IORDY=0, the wait counter increments. When the wait counter reaches IORDY_TIMEOUT, pulse TIMEOUT and leave anyway.
  - On the leaving edge: negate the strobe and, for a read, capture DOUT=IDE_DIN.
  - Go to HOLD with count=T_HOLD-1.
  - A CPU abort in ACTIVE or HOLD does not truncate the strobe.
- HOLD:
  - CSx_N, DA and IDE_DOUT/IDE_DOE remain stable.
  - At count 0: negate CSx_N and IDE_DOE, then go to ACK if DS=0, else RECOVER.
- ACK:
  - DSACK=0 while DS=0.
  - When DS is sampled high: DSACK=1 on that edge, go to RECOVER with count=T_RECOVER-1.
- RECOVER:
  - All strobes and chip-selects negated; counts to 0, then IDLE.
  - A CS/DS request during RECOVER is ignored. The CPU must re-strobe, so ds_d edge detection applies.
- Minimum strobe width is T_ACTIVE cycles; total cycle length is at least T_SETUP+T_ACTIVE+T_HOLD+1.
- Exactly one of IDE_CS0_N and IDE_CS1_N may be low, and only outside IDLE and RECOVER.
- IDE_DIOR_N and IDE_DIOW_N are never low together.
- DOUT holds its value until the next read capture.

Test Plan:
- Read, defaults, IORDY=1, A12=0, A=7, IDE_DIN=16'h50A0 -> CS0_N low at edge+1; DIOR_N low for exactly 6 cycles starting edge+3; DOUT=16'h50A0; DSACK low until DS high; CS0_N high for ≥3 cycles before the next start.
- Write, A12=1, A=6, DIN=16'h0004 -> CS1_N low, DA=6, IDE_DOE=1 and IDE_DOUT=16'h0004 from edge+1 through end of HOLD; DIOW_N low 6 cycles; DIOR_N stays 1.
- IORDY held low 10 cycles past the T_ACTIVE count -> strobe low 16 cycles; TIMEOUT stays 0. IORDY held low forever -> strobe ends after 6+200 cycles with a single TIMEOUT pulse; DSACK still returned.
- DS negated during SETUP -> no strobe, DSACK stays 1, RECOVER entered. DS negated during ACTIVE -> full 6-cycle strobe, no DSACK, then RECOVER.
- RESET asserted on the 3rd ACTIVE cycle -> next edge all IDE outputs inactive, DSACK=1, state IDLE; a fresh CS/DS edge afterwards runs a normal cycle.
- DS held low after ACK, then a new request during RECOVER -> no second cycle; a new cycle starts only after DS goes high then low in IDLE.
